dense_layer_mac: RTL and testbench



---
 rtl/dense_pkg.sv | 31 +++
 rtl/dense_layer_mac_mac_unit.sv | 59 +++++
 rtl/dense_layer_mac.sv | 177 +++++++++++++++++
 tb/tb_dense_layer_mac.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared types and helpers for the dense-layer MAC: FSM state encoding,
// default fixed-point format and the signed saturation function.
package dense_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_FRAC_W = 8;
    localparam int SAT_W      = 128;

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUTPUT  = 2'd2
    } state_e;

    // Clamp a wide signed value into the signed range of data_w bits.
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                    input int                     data_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (128'sd1 <<< (data_w - 1)) - 128'sd1;
        lo = ~hi;
        if (v > hi) begin
            sat = hi;
        end else if (v < lo) begin
            sat = lo;
        end else begin
            sat = v;
        end
    endfunction

endpackage

// File: rtl/dense_layer_mac_mac_unit.sv
// Signed multiply-accumulate slice: either seeds the accumulator with the
// shifted bias plus the product, or adds the product to the running sum.
module mac_unit
    import dense_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] bias_i,
    output logic [ACC_W-1:0]  sum_o
);

    logic signed [2*DATA_W-1:0] a_ext_s;
    logic signed [2*DATA_W-1:0] b_ext_s;
    logic signed [2*DATA_W-1:0] prod_s;
    logic        [ACC_W-1:0]    prod_ext_s;
    logic        [ACC_W-1:0]    init_s;
    logic        [ACC_W-1:0]    acc_q;
    logic        [ACC_W-1:0]    acc_d;

    assign a_ext_s    = {{DATA_W{a_i[DATA_W-1]}}, a_i};
    assign b_ext_s    = {{DATA_W{b_i[DATA_W-1]}}, b_i};
    assign prod_s     = a_ext_s * b_ext_s;
    assign prod_ext_s = {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
    assign init_s     = {{(ACC_W-DATA_W){bias_i[DATA_W-1]}}, bias_i} << FRAC_W;

    // Next accumulator value: bias-seeded on the first term of a neuron.
    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            if (load_i) begin
                acc_d = init_s + prod_ext_s;
            end else begin
                acc_d = acc_q + prod_ext_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign sum_o = acc_d;

endmodule

// File: rtl/dense_layer_mac.sv
// Fully-connected layer engine: LOAD an input vector, COMPUTE N_OUT dot
// products serially, then stream saturated results. Option: DENSE_LAYER_RELU_EN.
module dense_layer_mac
    import dense_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int N_IN   = 8,
    parameter int N_OUT  = 4,
    parameter int ACC_W  = 40,
    localparam int WA_W  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int BA_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              wt_we,
    input  logic [WA_W-1:0]   wt_addr,
    input  logic [DATA_W-1:0] wt_data,
    input  logic              bias_we,
    input  logic [BA_W-1:0]   bias_addr,
    input  logic [DATA_W-1:0] bias_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IW-1:0]   I_LAST = IW'(N_IN - 1);
    localparam logic [BA_W-1:0] J_LAST = BA_W'(N_OUT - 1);
    localparam logic [WA_W-1:0] P_LAST = WA_W'(N_IN * N_OUT - 1);

    if (ACC_W < 2 * DATA_W + $clog2(N_IN) + 1) begin : g_acc_chk
        $error("dense_layer_mac: ACC_W too narrow for DATA_W/N_IN");
    end

    state_e            state_q, state_d;
    logic [IW-1:0]     i_q, i_d;
    logic [BA_W-1:0]   j_q, j_d;
    logic [BA_W-1:0]   k_q, k_d;
    logic [WA_W-1:0]   ptr_q, ptr_d;
    logic              mac_en_s;
    logic              res_we_s;
    logic [ACC_W-1:0]  sum_s;
    logic signed [ACC_W-1:0] shift_s;
    logic [DATA_W-1:0] sat_s;
    logic [DATA_W-1:0] res_s;

    logic [DATA_W-1:0] x_q   [N_IN];
    logic [DATA_W-1:0] w_q   [N_IN*N_OUT];
    logic [DATA_W-1:0] b_q   [N_OUT];
    logic [DATA_W-1:0] res_q [N_OUT];

    mac_unit #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .en_i   (mac_en_s),
        .load_i (i_q == '0),
        .a_i    (x_q[i_q]),
        .b_i    (w_q[ptr_q]),
        .bias_i (b_q[j_q]),
        .sum_o  (sum_s)
    );

    // Arithmetic shift floors toward -inf; then clamp into DATA_W.
    assign shift_s = $signed(sum_s) >>> FRAC_W;
    assign sat_s   = DATA_W'(sat({{(SAT_W-ACC_W){shift_s[ACC_W-1]}}, shift_s}, DATA_W));
`ifdef DENSE_LAYER_RELU_EN
    assign res_s = sat_s[DATA_W-1] ? '0 : sat_s;
`else
    assign res_s = sat_s;
`endif

    // Next-state and counter logic.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        ptr_d    = ptr_q;
        mac_en_s = 1'b0;
        res_we_s = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    if (i_q == I_LAST) begin
                        i_d     = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end else begin
                    i_d = i_q;
                end
            end
            S_COMPUTE: begin
                mac_en_s = 1'b1;
                ptr_d    = (ptr_q == P_LAST) ? '0 : ptr_q + WA_W'(1);
                if (i_q == I_LAST) begin
                    res_we_s = 1'b1;
                    i_d      = '0;
                    if (j_q == J_LAST) begin
                        j_d     = '0;
                        state_d = S_OUTPUT;
                    end else begin
                        j_d = j_q + BA_W'(1);
                    end
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    if (k_q == J_LAST) begin
                        k_d     = '0;
                        state_d = S_LOAD;
                    end else begin
                        k_d = k_q + BA_W'(1);
                    end
                end else begin
                    k_d = k_q;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            ptr_q   <= ptr_d;
        end
    end

    // Data storage keeps its contents across reset; coefficients are frozen during COMPUTE.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && in_valid) begin
            x_q[i_q] <= in_data;
        end
        if (wt_we && state_q != S_COMPUTE && int'(wt_addr) < N_IN * N_OUT) begin
            w_q[wt_addr] <= wt_data;
        end
        if (bias_we && state_q != S_COMPUTE && int'(bias_addr) < N_OUT) begin
            b_q[bias_addr] <= bias_data;
        end
        if (res_we_s) begin
            res_q[j_q] <= res_s;
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_OUTPUT);
    assign busy      = (state_q == S_COMPUTE) || (state_q == S_OUTPUT);
    assign out_data  = out_valid ? res_q[k_q] : '0;
    assign out_last  = out_valid && (k_q == J_LAST);

endmodule

// File: tb/tb_dense_layer_mac.sv
// Directed bench for dense_layer_mac at N_IN=4, N_OUT=2, Q8.8 format.
module tb_dense_layer_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        wt_we;
    logic [2:0]  wt_addr;
    logic [15:0] wt_data;
    logic        bias_we;
    logic [0:0]  bias_addr;
    logic [15:0] bias_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;

    int total = 0;
    int bad   = 0;

    dense_layer_mac #(
        .DATA_W (16),
        .FRAC_W (8),
        .N_IN   (4),
        .N_OUT  (2),
        .ACC_W  (40)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .wt_we     (wt_we),
        .wt_addr   (wt_addr),
        .wt_data   (wt_data),
        .bias_we   (bias_we),
        .bias_addr (bias_addr),
        .bias_data (bias_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rexp(input logic [15:0] v);
`ifdef DENSE_LAYER_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input logic [2:0] a, input logic [15:0] d);
        wt_we = 1'b1; wt_addr = a; wt_data = d;
        step();
        wt_we = 1'b0;
    endtask

    task automatic write_b(input logic [0:0] a, input logic [15:0] d);
        bias_we = 1'b1; bias_addr = a; bias_data = d;
        step();
        bias_we = 1'b0;
    endtask

    task automatic fill_w(input logic [15:0] d);
        for (int n = 0; n < 8; n++) write_w(3'(n), d);
    endtask

    task automatic send_vec(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
        logic [15:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int n = 0; n < 4; n++) begin
            in_valid = 1'b1;
            in_data  = v[n];
            step();
        end
        in_valid = 1'b0;
    endtask

    // Waits for out_valid; lat counts cycles since the last input handshake.
    task automatic wait_out(input string tag, input bit poke);
        int lat;
        lat = 1;
        wt_addr = 3'd0;
        wt_data = 16'h7FFF;
        while (out_valid !== 1'b1 && lat < 40) begin
            wt_we = poke && (lat == 2);
            step();
            lat++;
        end
        wt_we = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'd9);
    endtask

    task automatic run_vec(input string tag, input bit poke,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d,
                           input logic [15:0] e0, input logic [15:0] e1);
        out_ready = 1'b1;
        send_vec(a, b, c, d);
        wait_out(tag, poke);
        check({tag, "_d0"}, 32'(out_data), 32'(e0));
        check({tag, "_l0"}, 32'(out_last), 32'd0);
        step();
        check({tag, "_d1"}, 32'(out_data), 32'(e1));
        check({tag, "_l1"}, 32'(out_last), 32'd1);
        step();
        check({tag, "_rdy"}, 32'({in_ready, busy, out_valid}), 32'b100);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; wt_we = 1'b0; wt_addr = '0;
        wt_data = '0; bias_we = 1'b0; bias_addr = '0; bias_data = '0; out_ready = 1'b0;
        step(); step(); step();
        rst = 1'b0;
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);

        fill_w(16'h0100);
        write_b(1'b0, 16'h0000);
        write_b(1'b1, 16'h0000);
        run_vec("basic", 1'b0, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0A00, 16'h0A00);

        // Weight write during COMPUTE must be ignored, now and for the next vector.
        run_vec("wpoke", 1'b1, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0A00, 16'h0A00);
        run_vec("wafter", 1'b0, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0A00, 16'h0A00);

        // Back-pressure in OUTPUT.
        out_ready = 1'b0;
        send_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        wait_out("stall", 1'b0);
        for (int n = 0; n < 5; n++) begin
            check("stall_d", 32'(out_data), 32'h0A00);
            check("stall_l", 32'(out_last), 32'd0);
            check("stall_v", 32'(out_valid), 32'd1);
            step();
        end
        out_ready = 1'b1;
        check("stall_d0", 32'(out_data), 32'h0A00);
        step();
        check("stall_d1", 32'(out_data), 32'h0A00);
        check("stall_l1", 32'(out_last), 32'd1);
        step();
        check("stall_rdy", 32'({in_ready, busy, out_valid}), 32'b100);

        // Reset pulse during COMPUTE cycle 3.
        send_vec(16'h0500, 16'h0600, 16'h0700, 16'h0800);
        step(); step();
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst", 32'({in_ready, busy, out_valid}), 32'b100);
        run_vec("after_rst", 1'b0, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0A00, 16'h0A00);

        fill_w(16'h7F00);
        write_b(1'b0, 16'h7FFF);
        write_b(1'b1, 16'h7FFF);
        run_vec("satpos", 1'b0, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7FFF, 16'h7FFF);

        fill_w(16'h8000);
        write_b(1'b0, 16'h0000);
        write_b(1'b1, 16'h0000);
        run_vec("satneg", 1'b0, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00,
                rexp(16'h8000), rexp(16'h8000));

        fill_w(16'h0000);
        write_b(1'b1, 16'hFF00);
        run_vec("bias", 1'b0, 16'h1234, 16'h0100, 16'hFF00, 16'h0042,
                16'h0000, rexp(16'hFF00));

        // -1/256 * 1 LSB floors to -1 LSB; +1 LSB product floors to 0.
        write_w(3'd0, 16'hFFFF);
        write_w(3'd4, 16'h0001);
        write_b(1'b1, 16'h0000);
        run_vec("trunc", 1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h0000,
                rexp(16'hFFFF), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
